// File: rtl/coef_bank_iir.sv
// -----------------------------------------------------------------------------
// coef_bank_iir
//
// Runtime-loadable coefficient bank for a recursive (IIR) filter section.
// Stores NUM_BANKS sets of NUM_COEF signed coefficients (b0, b1, b2, a1, a2 by
// convention). It presents one set to the filter datapath and changes that set
// only on a sample boundary. This keeps the filter from computing a sample with
// a mix of old and new coefficients.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   sample_tick         one-cycle strobe at each filter sample boundary
//   sel                 requested bank (level-sensitive)
//   wr_en/wr_bank/wr_idx/wr_data   coefficient write port
//   wr_err              one-cycle pulse after a write with an illegal address
//   rd_bank/rd_idx/rd_data         readback port, registered, 1-cycle latency
//   coef_out            active set; coefficient k at [k*WIDTH +: WIDTH]
//   act_sel             bank currently driving coef_out
//   pending             a commit is waiting for sample_tick
//   coef_update         one-cycle pulse the cycle after coef_out is reloaded
//   state_clr           one-cycle filter-state clear when the active bank changes
// -----------------------------------------------------------------------------
module coef_bank_iir #(
    parameter int WIDTH           = 22,
    parameter int NUM_COEF        = 5,
    parameter int NUM_BANKS       = 4,
    parameter bit CLEAR_ON_SWITCH = 1'b1,
    localparam int SW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int IW = (NUM_COEF  > 1) ? $clog2(NUM_COEF)  : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sample_tick,
    input  logic [SW-1:0]             sel,
    input  logic                      wr_en,
    input  logic [SW-1:0]             wr_bank,
    input  logic [IW-1:0]             wr_idx,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      wr_err,
    input  logic [SW-1:0]             rd_bank,
    input  logic [IW-1:0]             rd_idx,
    output logic [WIDTH-1:0]          rd_data,
    output logic [NUM_COEF*WIDTH-1:0] coef_out,
    output logic [SW-1:0]             act_sel,
    output logic                      pending,
    output logic                      coef_update,
    output logic                      state_clr
);

    typedef enum logic {IDLE, ARMED} state_t;

    // Address limits widened by one bit so the range checks also work when
    // NUM_BANKS or NUM_COEF is a power of two.
    localparam logic [SW:0] BANK_LIM = (SW+1)'(NUM_BANKS);
    localparam logic [IW:0] COEF_LIM = (IW+1)'(NUM_COEF);

    logic [WIDTH-1:0] mem [NUM_BANKS][NUM_COEF];

    state_t      state_q, state_d;
    logic        wpend_q, wpend_d;   // active bank written since last commit
    logic        commit;
    logic        wr_valid, wr_hit, dirty;
    logic        sel_ok, rd_ok;
    logic [SW-1:0] new_act;

    assign wr_valid = wr_en && ({1'b0, wr_idx} < COEF_LIM) && ({1'b0, wr_bank} < BANK_LIM);
    assign sel_ok   = ({1'b0, sel} < BANK_LIM);
    assign rd_ok    = ({1'b0, rd_idx} < COEF_LIM) && ({1'b0, rd_bank} < BANK_LIM);
    assign pending  = (state_q == ARMED);

    // Next-state logic. Dirty is evaluated against the bank that will be
    // active after this edge. On a commit, a same-edge write to the newly
    // selected bank re-arms, because the commit loads the pre-write contents.
    // NOTE: every signal gets a default before any condition, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        commit  = 1'b0;
        new_act = act_sel;
        wr_hit  = 1'b0;
        wpend_d = wpend_q;
        dirty   = 1'b0;
        state_d = state_q;

        commit  = (state_q == ARMED) && sample_tick;
        new_act = commit ? sel : act_sel;
        wr_hit  = wr_valid && (wr_bank == new_act);
        wpend_d = (commit ? 1'b0 : wpend_q) || wr_hit;
        dirty   = (sel != new_act) || wpend_d;
        state_d = dirty ? ARMED : IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments. This lets the
    // commit read mem[sel] as it stood before the write at the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wpend_q <= wpend_d;
        end
    end

    // Storage, readback and the active coefficient register.
    // NOTE: the storage array has an async reset on purpose. A fresh bank must
    // read back as zero. This makes it flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int k = 0; k < NUM_COEF; k++)
                    mem[b][k] <= '0;
            wr_err      <= 1'b0;
            rd_data     <= '0;
            coef_out    <= '0;
            act_sel     <= '0;
            coef_update <= 1'b0;
            state_clr   <= 1'b0;
        end else begin
            if (wr_valid)
                mem[wr_bank][wr_idx] <= wr_data;
            wr_err      <= wr_en && !wr_valid;
            rd_data     <= rd_ok ? mem[rd_bank][rd_idx] : '0;
            coef_update <= commit;
            state_clr   <= CLEAR_ON_SWITCH && commit && (sel != act_sel);
            if (commit) begin
                act_sel <= sel;
                for (int k = 0; k < NUM_COEF; k++)
                    coef_out[k*WIDTH +: WIDTH] <= sel_ok ? mem[sel][k] : '0;
            end
        end
    end

endmodule

// File: tb/tb_coef_bank_iir.sv
// -----------------------------------------------------------------------------
// tb_coef_bank_iir
//
// Self-checking bench for coef_bank_iir. A behavioural model tracks the banks,
// the active set and the pending condition. After every clock, all DUT outputs
// are compared with the model. Directed scenarios are followed by a random
// phase.
// -----------------------------------------------------------------------------
module tb_coef_bank_iir;

    localparam int W  = 22;
    localparam int NC = 5;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            sample_tick = 1'b0;
    logic [1:0]      sel = '0;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_bank = '0;
    logic [2:0]      wr_idx = '0;
    logic [W-1:0]    wr_data = '0;
    logic            wr_err;
    logic [1:0]      rd_bank = '0;
    logic [2:0]      rd_idx = '0;
    logic [W-1:0]    rd_data;
    logic [NC*W-1:0] coef_out;
    logic [1:0]      act_sel;
    logic            pending;
    logic            coef_update;
    logic            state_clr;

    coef_bank_iir #(
        .WIDTH(W), .NUM_COEF(NC), .NUM_BANKS(NB), .CLEAR_ON_SWITCH(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .sel(sel),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_err(wr_err), .rd_bank(rd_bank), .rd_idx(rd_idx), .rd_data(rd_data),
        .coef_out(coef_out), .act_sel(act_sel), .pending(pending),
        .coef_update(coef_update), .state_clr(state_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0] m_mem  [NB][NC];
    logic [W-1:0] m_coef [NC];
    int           m_act;
    bit           m_wdirty;   // active bank rewritten since its last load
    bit           m_pend;
    bit           e_upd, e_clr, e_err;
    logic [W-1:0] e_rd;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NC*W-1:0] model_coef_vec();
        logic [NC*W-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[k*W +: W] = m_coef[k];
        return v;
    endfunction

    function automatic logic [W-1:0] dut_coef(input int k);
        return coef_out[k*W +: W];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < NC; k++) m_mem[b][k] = '0;
        for (int k = 0; k < NC; k++) m_coef[k] = '0;
        m_act = 0; m_wdirty = 0; m_pend = 0;
        e_upd = 0; e_clr = 0; e_err = 0; e_rd = '0;
    endtask

    // Apply the bank's rules to the inputs currently on the pins.
    task automatic model_edge();
        bit do_commit;
        do_commit = m_pend && sample_tick;
        e_rd  = (int'(rd_idx) < NC) ? m_mem[rd_bank][rd_idx] : '0;
        e_err = wr_en && (int'(wr_idx) >= NC);
        e_upd = do_commit;
        e_clr = do_commit && (int'(sel) != m_act);
        if (do_commit) begin
            for (int k = 0; k < NC; k++) m_coef[k] = m_mem[sel][k];
            m_act    = int'(sel);
            m_wdirty = 0;
        end
        if (wr_en && int'(wr_idx) < NC) begin
            m_mem[wr_bank][wr_idx] = wr_data;
            if (int'(wr_bank) == m_act) m_wdirty = 1;
        end
        m_pend = (int'(sel) != m_act) || m_wdirty;
    endtask

    task automatic check_all();
        check("coef_out",    128'(coef_out),    128'(model_coef_vec()));
        check("act_sel",     128'(act_sel),     128'(m_act));
        check("pending",     128'(pending),     128'(m_pend));
        check("coef_update", 128'(coef_update), 128'(e_upd));
        check("state_clr",   128'(state_clr),   128'(e_clr));
        check("wr_err",      128'(wr_err),      128'(e_err));
        check("rd_data",     128'(rd_data),     128'(e_rd));
    endtask

    // One clock: model, edge, sample on the falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet();
        sample_tick = 1'b0;
        wr_en       = 1'b0;
    endtask

    task automatic write(input int b, input int i, input logic [W-1:0] d);
        wr_en = 1'b1; wr_bank = 2'(b); wr_idx = 3'(i); wr_data = d;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_coef"}, 128'(coef_out), 128'(0));
        check({tag, "_act"},  128'(act_sel),  128'(0));
        check({tag, "_pend"}, 128'(pending),  128'(0));
        check({tag, "_upd"},  128'(coef_update), 128'(0));
        check({tag, "_clr"},  128'(state_clr),   128'(0));
        check({tag, "_err"},  128'(wr_err),   128'(0));
        check({tag, "_rd"},   128'(rd_data),  128'(0));
    endtask

    task automatic readback_all();
        quiet();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 8; i++) begin
                rd_bank = 2'(b); rd_idx = 3'(i);
                cycle();
            end
    endtask

    logic [NC*W-1:0] saved;

    initial begin
        model_reset();

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        readback_all();

        // Load bank1 idx4, select bank1, hold without tick
        write(1, 4, 22'h3FC287);
        cycle();
        quiet();
        sel = 2'd1;
        repeat (5) cycle();
        check("hold_pending", 128'(pending), 128'(1));
        check("hold_coef",    128'(coef_out), 128'(0));
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        check("commit1_c4",  128'(dut_coef(4)), 128'(22'h3FC287));
        check("commit1_act", 128'(act_sel),     128'(1));
        check("commit1_upd", 128'(coef_update), 128'(1));
        check("commit1_clr", 128'(state_clr),   128'(1));
        cycle();
        check("commit1_upd_gone", 128'(coef_update), 128'(0));
        check("commit1_clr_gone", 128'(state_clr),   128'(0));

        // Write active bank on the same edge as a tick
        write(1, 4, 22'h3FE876);
        sample_tick = 1'b1;
        cycle();
        quiet();
        check("samewr_c4",   128'(dut_coef(4)), 128'(22'h3FC287));
        check("samewr_pend", 128'(pending),     128'(1));
        cycle();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        check("commit2_c4",  128'(dut_coef(4)), 128'(22'h3FE876));
        check("commit2_upd", 128'(coef_update), 128'(1));
        check("commit2_clr", 128'(state_clr),   128'(0));

        // Back to bank0, then toggle sel 0->2->0 and tick
        sel = 2'd0;
        cycle();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        check("back0_act", 128'(act_sel), 128'(0));
        saved = coef_out;
        sel = 2'd2; cycle();
        check("toggle_pend_up", 128'(pending), 128'(1));
        sel = 2'd0; cycle();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        check("toggle_pend", 128'(pending),     128'(0));
        check("toggle_upd",  128'(coef_update), 128'(0));
        check("toggle_coef", 128'(coef_out),    128'(saved));

        // Out-of-range writes
        write(0, 5, 22'h2AAAAA);
        cycle();
        check("err5", 128'(wr_err), 128'(1));
        write(3, 7, 22'h155555);
        cycle();
        check("err7", 128'(wr_err), 128'(1));
        quiet();
        cycle();
        check("err_gone", 128'(wr_err), 128'(0));
        readback_all();

        // Make bank2 active with data, re-arm with a write, then reset mid-operation
        write(2, 0, 22'h123456);
        sel = 2'd2;
        cycle();
        quiet();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        check("pre_rst_act", 128'(act_sel),     128'(2));
        check("pre_rst_c0",  128'(dut_coef(0)), 128'(22'h123456));
        write(2, 1, 22'h0ABCDE);
        cycle();
        quiet();
        check("pre_rst_pend", 128'(pending), 128'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        sel = 2'd0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        sample_tick = 1'b1;
        repeat (3) cycle();
        check("post_rst_upd",  128'(coef_update), 128'(0));
        check("post_rst_pend", 128'(pending),     128'(0));
        sample_tick = 1'b0;
        sel = 2'd2;
        cycle();
        check("rearm_pend", 128'(pending), 128'(1));
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        check("rearm_upd",  128'(coef_update), 128'(1));
        check("rearm_clr",  128'(state_clr),   128'(1));
        check("rearm_coef", 128'(coef_out),    128'(0));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) sel = 2'($urandom);
            sample_tick = ($urandom_range(0, 3) == 0);
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_bank     = 2'($urandom);
            wr_idx      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                                      : 3'($urandom_range(0, 4));
            wr_data     = W'($urandom);
            rd_bank     = 2'($urandom);
            rd_idx      = 3'($urandom);
            cycle();
        end
        quiet();
        readback_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coef_bank_iir.md
Name: coef_bank_iir

Overview:
- Runtime-loadable coefficient bank for the recursive (IIR) filter section.
- Holds NUM_BANKS sets of NUM_COEF signed fixed-point coefficients (b0, b1, b2, a1, a2 by convention, index 0..4).
- Presents the active set to the filter datapath and switches sets or applies reloads only on a sample boundary, so a filter never computes one sample with a mix of old and new coefficients.
- Optionally pulses a filter-state clear on every set change.

Parameters:
- WIDTH, 22: coefficient width, two's complement, same fixed-point format as the filter datapath.
- NUM_COEF, 5: coefficients per bank.
- NUM_BANKS, 4: number of selectable banks.
- CLEAR_ON_SWITCH, 1: when 1, `state_clr` pulses on commits that change the active bank.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe marking a filter sample boundary.
- sel  in  clog2(NUM_BANKS)  requested bank, level-sensitive.
- wr_en  in  1  coefficient write strobe.
- wr_bank  in  clog2(NUM_BANKS)  bank to write.
- wr_idx  in  clog2(NUM_COEF)  coefficient index to write.
- wr_data  in  WIDTH  coefficient value.
- wr_err  out  1  one-cycle pulse on a write with an out-of-range index.
- rd_bank  in  clog2(NUM_BANKS)  readback bank.
- rd_idx  in  clog2(NUM_COEF)  readback index.
- rd_data  out  WIDTH  stored value, registered, 1-cycle latency.
- coef_out  out  NUM_COEF*WIDTH  active coefficients; coefficient k at bits [k*WIDTH +: WIDTH].
- act_sel  out  clog2(NUM_BANKS)  bank currently driving coef_out.
- pending  out  1  a commit is waiting for sample_tick.
- coef_update  out  1  one-cycle pulse when coef_out changes.
- state_clr  out  1  one-cycle pulse, filter state reset request.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - all storage = 0, coef_out = 0, act_sel = 0;
  - pending, coef_update, state_clr, wr_err, rd_data all = 0.
- Writes:
  - wr_en with wr_idx < NUM_COEF: mem[wr_bank][wr_idx] takes wr_data at that edge.
  - wr_idx >= NUM_COEF, or wr_bank >= NUM_BANKS (non-power-of-2 case): no storage change; wr_err = 1 for one cycle.
  - Writing bank act_sel sets the dirty flag. Writing any other bank does not affect coef_out.
- Dirty flag: set when sel != act_sel, or after a valid write to bank act_sel. `pending` = dirty, registered.
- FSM, two states:
  - IDLE: dirty = 0.
  - ARMED: dirty = 1.
  - In ARMED with sample_tick = 1, a commit occurs at that edge:
    - act_sel <= sel; coef_out <= mem[sel] as read before any same-cycle write;
    - coef_update = 1 on the following cycle;
    - state_clr = 1 on the same cycle as coef_update, if CLEAR_ON_SWITCH and the new act_sel differs from the old one.
  - Return to IDLE unless dirty is re-set by that cycle's sel or write.
- sample_tick in IDLE: no action, no pulses.
- Write to bank sel at the same edge as a commit: the commit uses the old value; dirty stays set and the next sample_tick commits the new value.
- sel changing several times before a tick: only the value present at the tick is committed. If sel returns to act_sel with no pending write, dirty clears and no commit occurs.
- Latency: sample_tick edge to coef_out valid = 1 clock. Storage write to readback = 1 clock after the write edge.
- reset_n asserted mid-operation: immediate return to reset values. Pending writes and commits are lost.
- Arithmetic: none on the data path. Values are stored and forwarded bit-exact, with no sign extension or saturation.

Test Plan:
- Reset, then read all banks/indices and check coef_out -> every rd_data = 0, coef_out = 0, act_sel = 0, no pulses.
- Write bank1 idx4 = 22'h3FC287, set sel = 1, hold 5 cycles with no tick -> pending = 1, coef_out unchanged. Pulse sample_tick -> next cycle coef_out[4] = 22'h3FC287, act_sel = 1, coef_update = 1 and state_clr = 1 for exactly one cycle.
- With act_sel = 1, write bank1 idx4 = 22'h3FE876 on the same edge as a sample_tick -> coef_out[4] stays 22'h3FC287, pending remains 1. Next tick -> coef_out[4] = 22'h3FE876, coef_update = 1, state_clr = 0.
- With act_sel = 0, toggle sel 0->2->0 between ticks, then tick -> pending returns to 0, no coef_update, coef_out unchanged.
- Write with wr_idx = 5 (NUM_COEF = 5) -> wr_err pulse, readback of all bank entries unchanged.
- Assert reset_n low mid-ARMED (bank2 selected, write done) -> outputs return to 0 asynchronously. After release, tick produces no commit until sel or a write re-arms.
